mdu_iter: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers, living in the E stage of the five-stage core beside the ALU. It generalises the fixed-latency MDU: operand width, multiply latency and divide latency are parameters. The divider is iterative and retires several quotient bits per cycle. A pipeline flush aborts an in-flight operation. Optional multiply-accumulate is available. The conflict controller uses `busy` to stall HI/LO readers and writers.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_divider.sv | 92 +++++++++
 rtl/mdu_iter.sv | 191 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation codes presented on the op port by the decode stage
  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MTHI  = 4'd4,
    MTLO  = 4'd5,
    MADD  = 4'd6,
    MADDU = 4'd7,
    MSUB  = 4'd8,
    MSUBU = 4'd9
  } mdu_op_t;

  // Control FSM states of the unit
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_WAIT = 2'd3
  } mdu_state_t;

  // Quotient bits the divider must retire per cycle to finish within lat cycles
  function automatic int mdu_bits_per_cycle(input int width, input int lat);
    return (width + lat - 1) / lat;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring divider retiring K quotient bits per cycle.
// The first K bits are resolved on the load edge itself, so the result is
// ready ceil(WIDTH/K)-1 edges after load. Divide by zero yields an all-ones
// quotient and the dividend as remainder.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int ITERS = (WIDTH + K - 1) / K;
  localparam int N     = ITERS * K;
  localparam int CW    = $clog2(ITERS + 1);

  logic [N-1:0]     s_q, s_n;
  logic [WIDTH-1:0] r_q, r_n;
  logic [WIDTH-1:0] q_q, q_n;
  logic [WIDTH-1:0] d_q, d_in;
  logic [WIDTH:0]   r_t;
  logic [CW-1:0]    iter_q;
  logic             running_q;
  logic             done_q;

  // K restoring steps per cycle; a load starts from the fresh operands
  always_comb begin
    r_n  = load ? '0 : r_q;
    q_n  = load ? '0 : q_q;
    s_n  = load ? N'(dividend) : s_q;
    d_in = load ? divisor : d_q;
    r_t  = '0;
    for (int i = 0; i < K; i++) begin
      r_t = {r_n, s_n[N-1]};
      s_n = {s_n[N-2:0], 1'b0};
      q_n = {q_n[WIDTH-2:0], 1'b0};
      if (r_t >= {1'b0, d_in}) begin
        r_t    = r_t - {1'b0, d_in};
        q_n[0] = 1'b1;
      end
      r_n = r_t[WIDTH-1:0];
    end
  end

  // Iteration state: shift registers, partial remainder and step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      iter_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      iter_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (load) begin
      s_q       <= s_n;
      r_q       <= r_n;
      q_q       <= q_n;
      d_q       <= divisor;
      iter_q    <= CW'(1);
      running_q <= (ITERS > 1);
      done_q    <= (ITERS == 1);
    end else if (running_q) begin
      s_q    <= s_n;
      r_q    <= r_n;
      q_q    <= q_n;
      iter_q <= iter_q + CW'(1);
      if (iter_q == CW'(ITERS - 1)) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign quot = q_q;
  assign rem  = r_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: parametrised multi-cycle multiply/divide unit with HI/LO.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo}); without it those codes are no-ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             we,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int K       = mdu_bits_per_cycle(WIDTH, DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

  mdu_state_t         state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [2*WIDTH-1:0] res_q, mul_res, prod_s, prod_u;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   a_mag, b_mag, div_quot, div_rem;
  logic               quot_neg_q, rem_neg_q;
  logic               is_mul, is_div, div_signed;
  logic               mul_load, div_load, commit_mul, commit_div;
  logic               div_done, hilo_we;

  // Classify the requested op into multiply-class, divide or no-op
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      MULT, MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: is_mul = 1'b1;
`endif
      DIV, DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  assign div_signed = (op == DIV);
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign a_mag  = (div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (div_signed && b[WIDTH-1]) ? -b : b;

  // Full product or accumulated sum, captured on the start edge
  always_comb begin
    mul_res = prod_u;
    case (op)
      MULT: mul_res = prod_s;
`ifdef MDU_MADD_EN
      MADD:  mul_res = {hi_q, lo_q} + prod_s;
      MADDU: mul_res = {hi_q, lo_q} + prod_u;
      MSUB:  mul_res = {hi_q, lo_q} - prod_s;
      MSUBU: mul_res = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  // Next state, latency counter and load/commit strobes
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    mul_load   = 1'b0;
    div_load   = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && start) begin
          if (is_mul) begin
            state_n  = MUL_WAIT;
            cnt_n    = CNT_W'(1);
            mul_load = 1'b1;
          end else if (is_div) begin
            state_n  = DIV_RUN;
            cnt_n    = CNT_W'(1);
            div_load = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == MUL_L) begin
          state_n    = IDLE;
          cnt_n      = '0;
          commit_mul = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DIV_RUN, DIV_WAIT: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == DIV_L) begin
          state_n    = IDLE;
          cnt_n      = '0;
          commit_div = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
          if (state_q == DIV_RUN && div_done) state_n = DIV_WAIT;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Multiply result and divide sign-fix flags captured at start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else if (mul_load) begin
      res_q <= mul_res;
    end else if (div_load) begin
      quot_neg_q <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      rem_neg_q  <= div_signed & a[WIDTH-1];
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH),
    .K    (K)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .load    (div_load),
    .abort   (flush),
    .dividend(a_mag),
    .divisor (b_mag),
    .done    (div_done),
    .quot    (div_quot),
    .rem     (div_rem)
  );

  assign hilo_we = (state_q == IDLE) && !flush && !start && we;

  // HI/LO: commit results, or direct mthi/mtlo writes when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit_mul) begin
      {hi_q, lo_q} <= res_q;
    end else if (commit_div) begin
      lo_q <= quot_neg_q ? -div_quot : div_quot;
      hi_q <= rem_neg_q ? -div_rem : div_rem;
    end else if (hilo_we) begin
      if (op == MTHI) hi_q <= a;
      if (op == MTLO) lo_q <= a;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed, self-checking bench for mdu_iter (32-bit default
// instance with a cycle-level reference model, plus a 16-bit instance).
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_MADD_EN
  localparam int          MADD_LAT = 5;
  localparam logic [31:0] MADD_LO  = 32'd6;
`else
  localparam int          MADD_LAT = 0;
  localparam logic [31:0] MADD_LO  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, we, flush;
  mdu_op_t     op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  logic        s_start, s_we, s_flush;
  mdu_op_t     s_op;
  logic [15:0] s_a, s_b, s_hi, s_lo;
  logic        s_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  int          m_left;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(2), .DIV_LAT(3)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .we(s_we), .op(s_op), .a(s_a),
    .b(s_b), .flush(s_flush), .busy(s_busy), .hi(s_hi), .lo(s_lo)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one request for one cycle; caller is positioned at a falling edge
  task automatic applyStimulus(input logic s, input logic w, input logic f,
                               input mdu_op_t o, input logic [31:0] x,
                               input logic [31:0] y);
    start = s; we = w; flush = f; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; we = 1'b0; flush = 1'b0;
  endtask

  // Count remaining busy cycles (bounded) and compare with the expected count
  task automatic waitBusy(input string name, input bit narrow, input int exp_cycles);
    int n = 0;
    while ((narrow ? s_busy : busy) && n < 64) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, 64'(n), 64'(exp_cycles));
  endtask

  function automatic int model_latency(input mdu_op_t o);
    case (o)
      MULT, MULTU: return 5;
      DIV, DIVU:   return 10;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_result(input mdu_op_t o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc);
    longint      ps;
    logic [63:0] pu;
    logic [31:0] am, bm, q, r;
    bit          sgn;
    ps  = longint'($signed(x)) * longint'($signed(y));
    pu  = {32'd0, x} * {32'd0, y};
    sgn = (o == DIV);
    am  = (sgn && x[31]) ? 32'(-x) : x;
    bm  = (sgn && y[31]) ? 32'(-y) : y;
    if (bm == 0) begin q = '1; r = am; end
    else begin q = am / bm; r = am % bm; end
    if (sgn && (x[31] != y[31])) q = 32'(-q);
    if (sgn && x[31]) r = 32'(-r);
    case (o)
      MULT:  return 64'(ps);
      MULTU: return pu;
      MADD:  return acc + 64'(ps);
      MADDU: return acc + pu;
      MSUB:  return acc - 64'(ps);
      MSUBU: return acc - pu;
      default: return {r, q};
    endcase
  endfunction

  // Reference model of the 32-bit instance, advanced on each rising edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; pend <= '0;
    end else if (m_left > 0) begin
      if (flush) m_left <= 0;
      else if (m_left == 1) begin m_left <= 0; {m_hi, m_lo} <= pend; end
      else m_left <= m_left - 1;
    end else if (flush) begin
    end else if (start) begin
      if (model_latency(op) > 0) begin
        m_left <= model_latency(op);
        pend   <= model_result(op, a, b, {m_hi, m_lo});
      end
    end else if (we) begin
      if (op == MTHI) m_hi <= a;
      else if (op == MTLO) m_lo <= a;
    end
  end

  // Compare the 32-bit instance against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cmp_busy", 64'(busy), 64'(m_left > 0));
      checkOutput("cmp_hi", 64'(hi), 64'(m_hi));
      checkOutput("cmp_lo", 64'(lo), 64'(m_lo));
    end
  end

  // The conflict controller never issues start or we while busy
  always @(posedge clk) begin
    if (rst) begin
      assert (!(busy && (start || we))) else $error("[TB] protocol: request while busy");
      assert (!(s_busy && (s_start || s_we))) else $error("[TB] protocol: request while busy (16)");
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; we = 1'b0; flush = 1'b0; op = MULT; a = '0; b = '0;
    s_start = 1'b0; s_we = 1'b0; s_flush = 1'b0; s_op = MULT; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy16", 64'(s_busy), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, 0, MULT, 32'hFFFF_FFFD, 32'd7);
    waitBusy("mult_lat", 0, 5);
    checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    applyStimulus(1, 0, 0, DIV, 32'hFFFF_FFEF, 32'd5);
    waitBusy("div_lat", 0, 10);
    checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFE);

    applyStimulus(1, 0, 0, DIVU, 32'd100, 32'd0);
    waitBusy("divu0_lat", 0, 10);
    checkOutput("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("divu0_hi", 64'(hi), 64'd100);

    applyStimulus(1, 0, 0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitBusy("divmin_lat", 0, 10);
    checkOutput("divmin_lo", 64'(lo), 64'h8000_0000);
    checkOutput("divmin_hi", 64'(hi), 64'd0);

    applyStimulus(1, 0, 0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitBusy("multu_lat", 0, 5);
    checkOutput("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    checkOutput("multu_lo", 64'(lo), 64'h0000_0001);

    applyStimulus(1, 0, 0, DIVU, 32'd1000, 32'd7);
    waitBusy("divu_lat", 0, 10);
    checkOutput("divu_lo", 64'(lo), 64'd142);
    checkOutput("divu_hi", 64'(hi), 64'd6);

    applyStimulus(1, 0, 0, DIV, 32'd17, 32'hFFFF_FFFB);
    waitBusy("divneg_lat", 0, 10);
    checkOutput("divneg_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("divneg_hi", 64'(hi), 64'd2);

    applyStimulus(0, 1, 0, MTLO, 32'd0, 32'd0);
    checkOutput("mtlo", 64'(lo), 64'd0);
    applyStimulus(0, 1, 0, MTHI, 32'h1234, 32'd0);
    checkOutput("mthi", 64'(hi), 64'h1234);

    applyStimulus(1, 0, 0, MADD, 32'd2, 32'd3);
    waitBusy("madd_lat", 0, MADD_LAT);
    checkOutput("madd_hi", 64'(hi), 64'h1234);
    checkOutput("madd_lo", 64'(lo), 64'(MADD_LO));

    applyStimulus(1, 0, 0, DIVU, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("flush_prebusy", 64'(busy), 64'd1);
    applyStimulus(0, 0, 1, DIVU, 32'd0, 32'd0);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_hi", 64'(hi), 64'h1234);
    checkOutput("flush_lo", 64'(lo), 64'(MADD_LO));
    applyStimulus(1, 0, 0, MULTU, 32'd6, 32'd7);
    checkOutput("after_flush_accept", 64'(busy), 64'd1);
    waitBusy("after_flush_lat", 0, 5);
    checkOutput("after_flush_lo", 64'(lo), 64'd42);
    checkOutput("after_flush_hi", 64'(hi), 64'd0);

    applyStimulus(1, 1, 1, MULT, 32'd5, 32'd5);
    checkOutput("all3_busy", 64'(busy), 64'd0);
    checkOutput("all3_hi", 64'(hi), 64'd0);
    checkOutput("all3_lo", 64'(lo), 64'd42);
    applyStimulus(1, 1, 0, MTHI, 32'h55, 32'd0);
    checkOutput("start_over_we_hi", 64'(hi), 64'd0);
    applyStimulus(1, 0, 0, mdu_op_t'(4'd12), 32'd1, 32'd1);
    checkOutput("illegal_op_busy", 64'(busy), 64'd0);
    applyStimulus(0, 1, 0, MTHI, 32'hABCD, 32'd0);
    checkOutput("mthi2", 64'(hi), 64'hABCD);

    applyStimulus(1, 0, 0, MULT, 32'd9, 32'd9);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_hi", 64'(hi), 64'd0);
    checkOutput("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    s_op = DIVU; s_a = 16'hFFFF; s_b = 16'h0101; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    waitBusy("w16_divu_lat", 1, 3);
    checkOutput("w16_divu_lo", 64'(s_lo), 64'h00FF);
    checkOutput("w16_divu_hi", 64'(s_hi), 64'h0000);

    s_op = DIV; s_a = 16'hFF9C; s_b = 16'd7; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    waitBusy("w16_div_lat", 1, 3);
    checkOutput("w16_div_lo", 64'(s_lo), 64'hFFF2);
    checkOutput("w16_div_hi", 64'(s_hi), 64'hFFFE);

    s_op = MULT; s_a = 16'hFFFD; s_b = 16'd7; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    waitBusy("w16_mult_lat", 1, 2);
    checkOutput("w16_mult_hi", 64'(s_hi), 64'hFFFF);
    checkOutput("w16_mult_lo", 64'(s_lo), 64'hFFEB);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
